// File: rtl/code_lock_pkg.sv
// Shared types and constants for the code lock controller.
package code_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED,
        OPEN,
        SET_PW,
        LOCKOUT
    } lock_state_e;

    // RGB LEDs are active-low {R,G,B}
    localparam logic [2:0] RGB_GREEN = 3'b101;
    localparam logic [2:0] RGB_RED   = 3'b011;

    localparam int unsigned TRIES_W = 7;

    // Width of a counter that holds values 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Key, code and status bundle between the lock controller and the board.
interface code_lock_ctrl_if #(
    parameter int unsigned CW = 8
);
    logic          key_chk_n;
    logic          key_clr_n;
    logic          key_set_n;
    logic [CW-1:0] code_in;
    logic          open;
    logic          set_mode;
    logic          locked_out;
    logic [6:0]    tries_left;
    logic [3:0]    tries_tens;
    logic [3:0]    tries_ones;
    logic [2:0]    rgb_open;
    logic [2:0]    rgb_tries;

    modport master (
        output key_chk_n, key_clr_n, key_set_n, code_in,
        input  open, set_mode, locked_out, tries_left, tries_tens, tries_ones, rgb_open, rgb_tries
    );

    modport slave (
        input  key_chk_n, key_clr_n, key_set_n, code_in,
        output open, set_mode, locked_out, tries_left, tries_tens, tries_ones, rgb_open, rgb_tries
    );
endinterface

// File: rtl/key_debounce.sv
// Samples active-low raw keys on a shared slow tick and emits one-clock press pulses.
module key_debounce
    import code_lock_pkg::*;
#(
    parameter int unsigned N_KEYS     = 3,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_n_i,
    output logic [N_KEYS-1:0] press_o
);

    localparam int unsigned    CntW   = cnt_w(DEB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tick;
    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] samp_q, samp_d;
    logic [N_KEYS-1:0] press_q, press_d;

    always_comb begin
        tick    = (cnt_q == CntMax);
        cnt_d   = tick ? '0 : cnt_q + CntW'(1);
        samp_d  = tick ? sync2_q : samp_q;
        // falling edge between consecutive samples is a press
        press_d = tick ? (samp_q & ~sync2_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
            samp_q  <= '1;
            press_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sync1_q <= keys_n_i;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock: password compare, tries counter, password change and lockout.
// Optional auto-unlock from lockout when LOCKOUT_TIMER_EN is defined.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int unsigned                 DIGITS         = 2,
    parameter int unsigned                 DIGIT_W        = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]   PW_INIT        = '0,
    parameter int unsigned                 MAX_TRIES      = 5,
    parameter int unsigned                 DEB_CYCLES     = 1_000_000,
    parameter int unsigned                 LOCKOUT_CYCLES = 500_000_000
) (
    input logic             clk,
    input logic             rst_n,
    code_lock_ctrl_if.slave lock_io
);

    localparam int unsigned         CW       = DIGITS * DIGIT_W;
    localparam logic [TRIES_W-1:0]  MaxTries = TRIES_W'(MAX_TRIES);

    logic [2:0] press;
    logic       chk, clr, set;

    key_debounce #(
        .N_KEYS    (3),
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .keys_n_i({lock_io.key_set_n, lock_io.key_clr_n, lock_io.key_chk_n}),
        .press_o (press)
    );

    assign chk = press[0];
    assign clr = press[1];
    assign set = press[2];

    lock_state_e        state_q, state_d;
    logic [CW-1:0]      pw_q, pw_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [3:0]         tens_q, tens_d, ones_q, ones_d;

`ifdef LOCKOUT_TIMER_EN
    localparam int unsigned   LoW    = cnt_w(LOCKOUT_CYCLES);
    localparam logic [LoW-1:0] LoLoad = LoW'(LOCKOUT_CYCLES - 1);
    logic [LoW-1:0] lo_cnt_q, lo_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        tries_d = tries_q;
`ifdef LOCKOUT_TIMER_EN
        lo_cnt_d = lo_cnt_q;
`endif
        // clr > set > chk in every state
        unique case (state_q)
            LOCKED: begin
                if (clr) begin
                    tries_d = MaxTries;
                end else if (set) begin
                    tries_d = tries_q;
                end else if (chk) begin
                    if (lock_io.code_in == pw_q) begin
                        state_d = OPEN;
                        tries_d = MaxTries;
                    end else if (tries_q > TRIES_W'(1)) begin
                        tries_d = tries_q - TRIES_W'(1);
                    end else begin
                        tries_d = '0;
                        state_d = LOCKOUT;
`ifdef LOCKOUT_TIMER_EN
                        lo_cnt_d = LoLoad;
`endif
                    end
                end
            end
            OPEN: begin
                if (clr) begin
                    state_d = LOCKED;
                    tries_d = MaxTries;
                end else if (set) begin
                    state_d = SET_PW;
                end else if (chk) begin
                    state_d = LOCKED;
                end
            end
            SET_PW: begin
                if (clr) begin
                    state_d = OPEN;
                end else if (set) begin
                    state_d = SET_PW;
                end else if (chk) begin
                    pw_d    = lock_io.code_in;
                    state_d = OPEN;
                end
            end
            LOCKOUT: begin
                if (clr) begin
                    state_d = LOCKED;
                    tries_d = MaxTries;
`ifdef LOCKOUT_TIMER_EN
                    lo_cnt_d = '0;
                end else if (lo_cnt_q == '0) begin
                    state_d = LOCKED;
                    tries_d = MaxTries;
                end else begin
                    lo_cnt_d = lo_cnt_q - LoW'(1);
`endif
                end
            end
        endcase
        tens_d = 4'(tries_d / TRIES_W'(10));
        ones_d = 4'(tries_d % TRIES_W'(10));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCKED;
            pw_q    <= PW_INIT;
            tries_q <= MaxTries;
            tens_q  <= 4'(MAX_TRIES / 10);
            ones_q  <= 4'(MAX_TRIES % 10);
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            tries_q <= tries_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

`ifdef LOCKOUT_TIMER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_cnt_q <= '0;
        end else begin
            lo_cnt_q <= lo_cnt_d;
        end
    end
`endif

    assign lock_io.open       = (state_q == OPEN) || (state_q == SET_PW);
    assign lock_io.set_mode   = (state_q == SET_PW);
    assign lock_io.locked_out = (state_q == LOCKOUT);
    assign lock_io.tries_left = tries_q;
    assign lock_io.tries_tens = tens_q;
    assign lock_io.tries_ones = ones_q;
    assign lock_io.rgb_open   = lock_io.open ? RGB_GREEN : RGB_RED;
    assign lock_io.rgb_tries  = lock_io.locked_out ? RGB_RED : RGB_GREEN;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed self-checking bench for code_lock_ctrl (DEB_CYCLES=4, LOCKOUT_CYCLES=64).
module tb_code_lock_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    code_lock_ctrl_if #(.CW(8)) lock_if ();

    code_lock_ctrl #(
        .DIGITS        (2),
        .DIGIT_W       (4),
        .PW_INIT       (8'h00),
        .MAX_TRIES     (5),
        .DEB_CYCLES    (4),
        .LOCKOUT_CYCLES(64)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .lock_io(lock_if)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // c/k/s = chk/clr/set pressed together, held 12 clk then released 12 clk
    task automatic press(input logic c, input logic k, input logic s);
        lock_if.key_chk_n = ~c;
        lock_if.key_clr_n = ~k;
        lock_if.key_set_n = ~s;
        step(12);
        lock_if.key_chk_n = 1'b1;
        lock_if.key_clr_n = 1'b1;
        lock_if.key_set_n = 1'b1;
        step(12);
    endtask

    // Bouncy chk: 1-cycle glitches on make and break, long hold in between
    task automatic bounce_chk();
        logic [3:0] make_pat;
        logic [3:0] brk_pat;
        make_pat = 4'b1010;
        brk_pat  = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            lock_if.key_chk_n = make_pat[i];
            step(1);
        end
        lock_if.key_chk_n = 1'b0;
        step(100);
        for (int i = 0; i < 4; i++) begin
            lock_if.key_chk_n = brk_pat[i];
            step(1);
        end
        lock_if.key_chk_n = 1'b1;
        step(12);
    endtask

    initial begin
        lock_if.key_chk_n = 1'b1;
        lock_if.key_clr_n = 1'b1;
        lock_if.key_set_n = 1'b1;
        lock_if.code_in   = 8'h00;
        step(3);
        rst_n = 1'b1;
        step(2);

        // 1: reset values, then correct code opens
        check("rst_open", 32'(lock_if.open), 32'd0);
        check("rst_set_mode", 32'(lock_if.set_mode), 32'd0);
        check("rst_locked_out", 32'(lock_if.locked_out), 32'd0);
        check("rst_tries", 32'(lock_if.tries_left), 32'd5);
        check("rst_tens", 32'(lock_if.tries_tens), 32'd0);
        check("rst_ones", 32'(lock_if.tries_ones), 32'd5);
        check("rst_rgb_open", 32'(lock_if.rgb_open), 32'b011);
        check("rst_rgb_tries", 32'(lock_if.rgb_tries), 32'b101);
        press(1'b1, 1'b0, 1'b0);
        check("t1_open", 32'(lock_if.open), 32'd1);
        check("t1_rgb_open", 32'(lock_if.rgb_open), 32'b101);
        check("t1_tries", 32'(lock_if.tries_left), 32'd5);
        check("t1_ones", 32'(lock_if.tries_ones), 32'd5);

        // 2: relock, then five wrong codes to lockout
        press(1'b1, 1'b0, 1'b0);
        check("t2_relock", 32'(lock_if.open), 32'd0);
        lock_if.code_in = 8'h12;
        for (int i = 4; i >= 0; i--) begin
            press(1'b1, 1'b0, 1'b0);
            check("t2_tries", 32'(lock_if.tries_left), 32'(i));
            check("t2_ones", 32'(lock_if.tries_ones), 32'(i));
        end
        check("t2_locked_out", 32'(lock_if.locked_out), 32'd1);
        check("t2_rgb_tries", 32'(lock_if.rgb_tries), 32'b011);
        lock_if.code_in = 8'h00;
        press(1'b1, 1'b0, 1'b0);
        check("t2_ign_open", 32'(lock_if.open), 32'd0);
        check("t2_ign_lo", 32'(lock_if.locked_out), 32'd1);
        check("t2_ign_tries", 32'(lock_if.tries_left), 32'd0);

        // 5: leaving lockout by timer or by clr
`ifdef LOCKOUT_TIMER_EN
        step(40);
        check("t5_timer_lo", 32'(lock_if.locked_out), 32'd0);
        check("t5_timer_tries", 32'(lock_if.tries_left), 32'd5);
`else
        step(40);
        check("t5_still_lo", 32'(lock_if.locked_out), 32'd1);
        press(1'b0, 1'b1, 1'b0);
        check("t5_clr_lo", 32'(lock_if.locked_out), 32'd0);
        check("t5_clr_tries", 32'(lock_if.tries_left), 32'd5);
`endif
        check("t5_open", 32'(lock_if.open), 32'd0);

        // 3: password change
        press(1'b1, 1'b0, 1'b0);
        check("t3_open", 32'(lock_if.open), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        check("t3_set_mode", 32'(lock_if.set_mode), 32'd1);
        check("t3_set_open", 32'(lock_if.open), 32'd1);
        lock_if.code_in = 8'h3A;
        press(1'b1, 1'b0, 1'b0);
        check("t3_store_mode", 32'(lock_if.set_mode), 32'd0);
        check("t3_store_open", 32'(lock_if.open), 32'd1);
        press(1'b1, 1'b0, 1'b0);
        check("t3_relock", 32'(lock_if.open), 32'd0);
        lock_if.code_in = 8'h00;
        press(1'b1, 1'b0, 1'b0);
        check("t3_old_pw_open", 32'(lock_if.open), 32'd0);
        check("t3_old_pw_tries", 32'(lock_if.tries_left), 32'd4);
        lock_if.code_in = 8'h3A;
        press(1'b1, 1'b0, 1'b0);
        check("t3_new_pw_open", 32'(lock_if.open), 32'd1);
        check("t3_new_pw_tries", 32'(lock_if.tries_left), 32'd5);

        // 4: bounce gives one pulse; clr beats chk on the same tick
        press(1'b1, 1'b0, 1'b0);
        check("t4_relock", 32'(lock_if.open), 32'd0);
        lock_if.code_in = 8'h55;
        bounce_chk();
        check("t4_bounce_tries", 32'(lock_if.tries_left), 32'd4);
        press(1'b1, 1'b1, 1'b0);
        check("t4_clr_wins", 32'(lock_if.tries_left), 32'd5);
        check("t4_clr_open", 32'(lock_if.open), 32'd0);

        // 6: async reset in SET_PW restores PW_INIT
        lock_if.code_in = 8'h3A;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("t6_in_set", 32'(lock_if.set_mode), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_open", 32'(lock_if.open), 32'd0);
        check("t6_rst_set", 32'(lock_if.set_mode), 32'd0);
        check("t6_rst_tries", 32'(lock_if.tries_left), 32'd5);
        step(2);
        rst_n = 1'b1;
        step(2);
        press(1'b1, 1'b0, 1'b0);
        check("t6_3a_rejected", 32'(lock_if.open), 32'd0);
        check("t6_3a_tries", 32'(lock_if.tries_left), 32'd4);
        lock_if.code_in = 8'h00;
        press(1'b1, 1'b0, 1'b0);
        check("t6_00_open", 32'(lock_if.open), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
